// File: rtl/plic_pkg.sv
// plic_pkg: shared PLIC register offsets, scanner state encoding and a constant log2 helper
package plic_pkg;
   localparam logic [23:0] PRIO_BASE  = 24'h000000;
   localparam logic [23:0] PEND_BASE  = 24'h001000;
   localparam logic [23:0] EN_BASE    = 24'h002000;
   localparam logic [23:0] EN_STRIDE  = 24'h000080;
   localparam logic [23:0] CTX_BASE   = 24'h200000;
   localparam logic [23:0] CTX_STRIDE = 24'h001000;
   localparam logic [23:0] CLAIM_OFS  = 24'h000004;
   typedef enum logic {S_SCAN = 1'b0, S_COMMIT = 1'b1} state_e;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int k = 0; k < 32; k++) if ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/plic_gateway.sv
// plic_gateway: per-source level gateway holding pending and in-flight state
module plic_gateway (
   input  logic CLK,
   input  logic RST,
   input  logic irq,
   input  logic claim_hit,
   input  logic complete_hit,
   output logic pending
);
   logic pending_q, pending_d, in_flight_q, in_flight_d;
   always_comb begin
      pending_d   = claim_hit ? 1'b0 : pending_q | (irq & ~in_flight_q);
      in_flight_d = claim_hit | (in_flight_q & ~complete_hit);
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         pending_q   <= 1'b0;
         in_flight_q <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         in_flight_q <= in_flight_d;
      end
   end
   assign pending = pending_q;
endmodule

// File: rtl/plic_claim_arbiter.sv
// plic_claim_arbiter: one-context PLIC gateways, serial priority scanner and claim/complete handshake
module plic_claim_arbiter
   import plic_pkg::*;
#(
   parameter  int N_INT_SRC  = 32,
   parameter  int W_INT_PRIO = 32,
   localparam int W_ID       = clog2(N_INT_SRC)
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic [N_INT_SRC-1:0]            w_irq,
   input  logic [N_INT_SRC*W_INT_PRIO-1:0] w_priority,
   input  logic [N_INT_SRC-1:0]            w_enable,
   input  logic [W_INT_PRIO-1:0]           w_threshold,
   input  logic                            w_claim,
   input  logic                            w_complete,
   input  logic [W_ID-1:0]                 w_complete_id,
   output logic [W_ID-1:0]                 w_claim_id,
   output logic [N_INT_SRC-1:0]            w_pending,
   output logic                            w_eip
);
   logic [W_INT_PRIO-1:0] prio [N_INT_SRC];
   logic [N_INT_SRC-1:0]  pending;
   state_e                state_q, state_d;
   logic [W_ID-1:0]       idx_q, idx_d, acc_id_q, acc_id_d, max_id_q, max_id_d, claim_id_q, claim_id_d;
   logic [W_INT_PRIO-1:0] acc_prio_q, acc_prio_d, max_prio_q, max_prio_d;
   logic                  eip_q, eip_d, claim_ok, cand;
   always_comb for (int i = 0; i < N_INT_SRC; i++) prio[i] = w_priority[i*W_INT_PRIO +: W_INT_PRIO];
   // a claim only succeeds if the committed winner is still pending and enabled
   assign claim_ok = w_claim & (max_id_q != '0) & pending[max_id_q] & w_enable[max_id_q];
   assign cand = pending[idx_q] & w_enable[idx_q] & (prio[idx_q] > w_threshold)
               & (prio[idx_q] != '0) & (prio[idx_q] > acc_prio_q);
   genvar g;
   generate
      for (g = 0; g < N_INT_SRC; g++) begin : gen_gw
         plic_gateway u_gw (
            .CLK          (CLK),
            .RST          (RST),
            .irq          (w_irq[g] & (g != 0)),
            .claim_hit    (claim_ok & (max_id_q == W_ID'(g))),
            .complete_hit (w_complete & (w_complete_id == W_ID'(g))),
            .pending      (pending[g])
         );
      end
   endgenerate
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      acc_id_d   = acc_id_q;
      acc_prio_d = acc_prio_q;
      max_id_d   = max_id_q;
      max_prio_d = max_prio_q;
      eip_d      = eip_q;
      claim_id_d = w_claim ? (claim_ok ? max_id_q : '0) : claim_id_q;
      if (state_q == S_SCAN) begin
         acc_id_d   = cand ? idx_q : acc_id_q;
         acc_prio_d = cand ? prio[idx_q] : acc_prio_q;
         idx_d      = idx_q + 1'b1;
         state_d    = (idx_q == W_ID'(N_INT_SRC - 1)) ? S_COMMIT : S_SCAN;
      end else begin
         max_id_d   = acc_id_q;
         max_prio_d = acc_prio_q;
         eip_d      = acc_id_q != '0;
         acc_id_d   = '0;
         acc_prio_d = '0;
         idx_d      = W_ID'(1);
         state_d    = S_SCAN;
      end
      // any claim invalidates the committed winner and restarts arbitration
      if (w_claim) begin
         eip_d      = 1'b0;
         max_id_d   = '0;
         acc_id_d   = '0;
         acc_prio_d = '0;
         idx_d      = W_ID'(1);
         state_d    = S_SCAN;
      end
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_SCAN;
         idx_q      <= W_ID'(1);
         acc_id_q   <= '0;
         acc_prio_q <= '0;
         max_id_q   <= '0;
         max_prio_q <= '0;
         eip_q      <= 1'b0;
         claim_id_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_id_q   <= acc_id_d;
         acc_prio_q <= acc_prio_d;
         max_id_q   <= max_id_d;
         max_prio_q <= max_prio_d;
         eip_q      <= eip_d;
         claim_id_q <= claim_id_d;
      end
   end
   assign w_claim_id = claim_id_q;
   assign w_pending  = pending;
   assign w_eip      = eip_q;
endmodule
